// File: rtl/digit_scan.sv
// digit_scan: debounced two-digit BCD pattern detector.
//   SW2 holds the tens digit and SW1 the ones digit. OUT asserts once the sampled
//   pair equals {TARGET_TENS,TARGET_ONES} and has stayed unchanged for
//   STABLE_CYCLES sample edges. INVALID flags any non-BCD nibble in the newest
//   sample.
//   Optional feature macro: DIGIT_SCAN_HEX_EN adds active-low 7-segment
//   outputs, with segment order {g,f,e,d,c,b,a}, for both sampled digits.
//   Clock synchronisation of the switches is done outside this block.
module digit_scan #(
  parameter logic [3:0] TARGET_TENS   = 4'd7,
  parameter logic [3:0] TARGET_ONES   = 4'd1,
  parameter int         STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] SW1,
  input  logic [3:0] SW2,
  output logic       OUT,
  output logic       INVALID
`ifdef DIGIT_SCAN_HEX_EN
  ,
  output logic [6:0] HEX_ONES,
  output logic [6:0] HEX_TENS
`endif
);

  // The stability counter saturates at STABLE_CYCLES, so it needs just enough
  // bits to hold that value. It is always at least one bit wide.
  localparam int CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [7:0] TARGET = {TARGET_TENS, TARGET_ONES};

  logic [7:0]       s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             invalid_q, invalid_d;
  logic [7:0]       new_sample;
  logic             new_valid;

  assign new_sample = {SW2, SW1};
  assign new_valid  = (new_sample[7:4] <= 4'd9) && (new_sample[3:0] <= 4'd9);

  // Next-state logic for the sample, the stability count and the flags.
  // OUT is decided from the values being loaded now. This lets the output
  // rise on the same edge at which the count reaches its ceiling.
  always_comb begin
    s_d = new_sample;
    if (new_sample != s_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    invalid_d = !new_valid;
    // A non-BCD target can never match, because validity is required first.
    out_d     = new_valid && (new_sample == TARGET) && (cnt_d == CNT_MAX);
  end

  // State register with a synchronous, active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_q       <= 8'h00;
      cnt_q     <= '0;
      out_q     <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      invalid_q <= invalid_d;
    end
  end

  assign OUT     = out_q;
  assign INVALID = invalid_q;

`ifdef DIGIT_SCAN_HEX_EN
  logic [6:0] hex_ones_q, hex_ones_d;
  logic [6:0] hex_tens_q, hex_tens_d;

  // Active-low decode with segment order {g,f,e,d,c,b,a}.
  // Any nibble above 9 is shown as "E".
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b0000110;
    endcase
    return seg;
  endfunction

  // Decode the digits being sampled this edge, so each display tracks s.
  always_comb begin
    hex_ones_d = seg_decode(new_sample[3:0]);
    hex_tens_d = seg_decode(new_sample[7:4]);
  end

  // Display registers. Reset leaves every segment off (blank).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hex_ones_q <= 7'h7F;
      hex_tens_q <= 7'h7F;
    end else begin
      hex_ones_q <= hex_ones_d;
      hex_tens_q <= hex_tens_d;
    end
  end

  assign HEX_ONES = hex_ones_q;
  assign HEX_TENS = hex_tens_q;
`endif

endmodule

// File: tb/tb_digit_scan.sv
// tb_digit_scan: self-checking bench for digit_scan with its default parameters
// (target 71, two stable edges).
//   It applies a table of directed vectors, then a full 0..255 sweep, then
//   randomized stimulus. Each result is compared with a run-length reference
//   model. Define DIGIT_SCAN_HEX_EN to also check the display outputs.
module tb_digit_scan;

  localparam logic [7:0] TGT = 8'h71;
  localparam int         SC  = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] SW1, SW2;
  logic       OUT, INVALID;
`ifdef DIGIT_SCAN_HEX_EN
  logic [6:0] HEX_ONES, HEX_TENS;
`endif

  digit_scan dut (
    .clk     (clk),
    .reset_n (reset_n),
    .SW1     (SW1),
    .SW2     (SW2),
    .OUT     (OUT),
    .INVALID (INVALID)
`ifdef DIGIT_SCAN_HEX_EN
    ,
    .HEX_ONES(HEX_ONES),
    .HEX_TENS(HEX_TENS)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the current sample, and how many consecutive edges it
  // has been seen unchanged (unbounded, compared with >=).
  logic [7:0] m_prev = 8'h00;
  int         m_run  = 0;
  logic       m_out  = 1'b0;
  logic       m_inv  = 1'b0;
  logic [6:0] m_hex_ones = 7'h7F;
  logic [6:0] m_hex_tens = 7'h7F;

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (n > 4'd9) return 7'b0000110;
    return tbl[n];
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Apply one edge of stimulus, advance the model, and settle just after the edge.
  task automatic step(input logic r, input logic [7:0] sw);
    logic v;
    reset_n    = r;
    {SW2, SW1} = sw;
    @(posedge clk);
    if (!r) begin
      m_prev = 8'h00; m_run = 0; m_out = 1'b0; m_inv = 1'b0;
      m_hex_ones = 7'h7F; m_hex_tens = 7'h7F;
    end else begin
      if (sw == m_prev) m_run = m_run + 1;
      else              m_run = 0;
      m_prev = sw;
      v = (sw[7:4] <= 4'd9) && (sw[3:0] <= 4'd9);
      m_inv = !v;
      m_out = v && (sw == TGT) && (m_run >= SC);
      m_hex_ones = seg_ref(sw[3:0]);
      m_hex_tens = seg_ref(sw[7:4]);
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_out"}, {7'b0, OUT}, {7'b0, m_out});
    check({tag, "_inv"}, {7'b0, INVALID}, {7'b0, m_inv});
`ifdef DIGIT_SCAN_HEX_EN
    check({tag, "_hex1"}, {1'b0, HEX_ONES}, {1'b0, m_hex_ones});
    check({tag, "_hex10"}, {1'b0, HEX_TENS}, {1'b0, m_hex_tens});
`endif
  endtask

  typedef struct {
    logic       rst_n;
    logic [7:0] sw;
    logic       out;
    logic       inv;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  initial begin
    // Each row gives the inputs for one edge and the outputs expected just after it.
    tbl[0]  = '{1'b0, 8'h71, 1'b0, 1'b0};  // reset held 3 cycles with 71 applied
    tbl[1]  = '{1'b0, 8'h71, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h71, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h71, 1'b0, 1'b0};  // E0
    tbl[4]  = '{1'b1, 8'h71, 1'b0, 1'b0};  // E1
    tbl[5]  = '{1'b1, 8'h71, 1'b1, 1'b0};  // E2: rises
    tbl[6]  = '{1'b1, 8'h71, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 8'h7A, 1'b0, 1'b1};  // invalid ones digit
    tbl[8]  = '{1'b1, 8'h7A, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 8'h71, 1'b0, 1'b0};  // 71 held one cycle only
    tbl[10] = '{1'b1, 8'h70, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 8'h70, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 8'h71, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 8'h71, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 8'h71, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 8'h71, 1'b0, 1'b0};  // 1-cycle reset while stable
    tbl[16] = '{1'b1, 8'h71, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 8'h71, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 8'h71, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 8'hA1, 1'b0, 1'b1};  // invalid tens digit
    tbl[20] = '{1'b1, 8'h71, 1'b0, 1'b0};

    reset_n = 1'b0;
    {SW2, SW1} = 8'h00;

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].rst_n, tbl[i].sw);
      check($sformatf("vec%0d_out", i), {7'b0, OUT}, {7'b0, tbl[i].out});
      check($sformatf("vec%0d_inv", i), {7'b0, INVALID}, {7'b0, tbl[i].inv});
      $display("vec %0d rst_n=%b sw=%h OUT=%b INVALID=%b", i, tbl[i].rst_n, tbl[i].sw, OUT, INVALID);
    end

`ifdef DIGIT_SCAN_HEX_EN
    step(1'b0, 8'h00);
    check("hex_reset_ones", {1'b0, HEX_ONES}, 8'h7F);
    check("hex_reset_tens", {1'b0, HEX_TENS}, 8'h7F);
    step(1'b1, 8'h39);
    check("hex39_tens", {1'b0, HEX_TENS}, {1'b0, 7'b0110000});
    check("hex39_ones", {1'b0, HEX_ONES}, {1'b0, 7'b0010000});
    $display("hex sw=39 HEX_TENS=%b HEX_ONES=%b", HEX_TENS, HEX_ONES);
`endif

    // 8'h00 held through reset counts as stable from the first edge after release.
    step(1'b0, 8'h00);
    step(1'b1, 8'h00);
    check_model("hold00_a");
    step(1'b1, 8'h00);
    check_model("hold00_b");

    // Sweep every code, holding each one for 10 edges.
    for (int v = 0; v < 256; v++) begin
      for (int k = 0; k < 10; k++) begin
        step(1'b1, 8'(v));
        check_model($sformatf("sweep%02h_%0d", v, k));
      end
      $display("sweep sw=%h OUT=%b INVALID=%b", 8'(v), OUT, INVALID);
    end

    // Random stimulus, biased toward the target and nearby values, with
    // random hold lengths and occasional reset.
    for (int t = 0; t < 400; t++) begin
      logic [7:0] sw;
      logic       r;
      int         hold;
      case ($urandom_range(0, 3))
        0, 1:    sw = TGT;
        2:       sw = {4'h7, 4'($urandom_range(0, 15))};
        default: sw = 8'($urandom);
      endcase
      r    = ($urandom_range(0, 19) != 0);
      hold = $urandom_range(1, 5);
      for (int k = 0; k < hold; k++) begin
        step(r, sw);
        check_model($sformatf("rand%0d_%0d", t, k));
      end
      $display("rand %0d rst_n=%b sw=%h hold=%0d OUT=%b INVALID=%b", t, r, sw, hold, OUT, INVALID);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
